// File: rtl/d_ff_pkg.sv
// d_ff_pkg: shared constants and the priority-decode naming for the d_ff register.
// Optional feature macro used by the importing files: D_FF_CLK_ENABLE_EN (adds clock enable).
package d_ff_pkg;

   // Default per-bit values loaded by the asynchronous clear and preset.
   localparam logic D_FF_CLR_BIT = 1'b0;
   localparam logic D_FF_PRE_BIT = 1'b1;

   // Which source controls a flop cell: clear beats preset, preset beats the clock.
   typedef enum logic [1:0] {
      CTRL_CLR = 2'd0,
      CTRL_PRE = 2'd1,
      CTRL_CLK = 2'd2
   } ctrl_e;

   // Priority decode of the active-low asynchronous controls.
   function automatic ctrl_e ctrl_decode(input logic clrn, input logic prn);
      ctrl_e c;
      if (!clrn) begin
         c = CTRL_CLR;
      end else if (!prn) begin
         c = CTRL_PRE;
      end else begin
         c = CTRL_CLK;
      end
      return c;
   endfunction

endpackage : d_ff_pkg

// File: rtl/d_ff_bit.sv
// d_ff_bit: one positive-edge flop cell with asynchronous active-low clear and preset.
// With D_FF_CLK_ENABLE_EN defined the cell gains a synchronous clock enable (ena).
module d_ff_bit
   import d_ff_pkg::*;
#(
   parameter logic CLR_BIT = D_FF_CLR_BIT,
   parameter logic PRE_BIT = D_FF_PRE_BIT
) (
   input  logic prn,
   input  logic clk,
   input  logic d,
   input  logic clrn,
   output logic q,
   output logic qn
`ifdef D_FF_CLK_ENABLE_EN
   ,
   input  logic ena
`endif
);

   logic state_q;

   // Storage: clear has priority over preset, both override the clock edge.
   always_ff @(posedge clk or negedge clrn or negedge prn) begin
      if (!clrn) begin
         state_q <= CLR_BIT;
      end else if (!prn) begin
         state_q <= PRE_BIT;
`ifdef D_FF_CLK_ENABLE_EN
      end else if (ena) begin
`else
      end else begin
`endif
         state_q <= d;
      end
   end

   // Both outputs come from the same state so qn is always the exact complement.
   assign q  = state_q;
   assign qn = ~state_q;

endmodule : d_ff_bit

// File: rtl/d_ff.sv
// d_ff: WIDTH-bit positive-edge register built from independent d_ff_bit cells,
// with asynchronous active-low clear (clrn) and preset (prn), true and complement outputs.
// Optional feature: define D_FF_CLK_ENABLE_EN to add the ena clock-enable input.
module d_ff
   import d_ff_pkg::*;
#(
   parameter int unsigned      WIDTH   = 1,
   parameter logic [WIDTH-1:0] CLR_VAL = {WIDTH{D_FF_CLR_BIT}},
   parameter logic [WIDTH-1:0] PRE_VAL = {WIDTH{D_FF_PRE_BIT}}
) (
   input  logic             prn,
   input  logic             clk,
   input  logic [WIDTH-1:0] d,
   input  logic             clrn,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn
`ifdef D_FF_CLK_ENABLE_EN
   ,
   input  logic             ena
`endif
);

   genvar gi;

   // One cell per bit, each with its own clear/preset value bit.
   generate
      for (gi = 0; gi < int'(WIDTH); gi++) begin : g_bit
         d_ff_bit #(
            .CLR_BIT (CLR_VAL[gi]),
            .PRE_BIT (PRE_VAL[gi])
         ) u_bit (
            .prn  (prn),
            .clk  (clk),
            .d    (d[gi]),
            .clrn (clrn),
            .q    (q[gi]),
            .qn   (qn[gi])
`ifdef D_FF_CLK_ENABLE_EN
            ,
            .ena  (ena)
`endif
         );
      end
   endgenerate

endmodule : d_ff

// File: tb/tb_d_ff.sv
// tb_d_ff: self-checking bench for d_ff (WIDTH=1 and WIDTH=8 instances).
// Timed async/clock sequence first, then a table of synchronous vectors scored via a queue.
`timescale 1ns/1ps
module tb_d_ff;

   logic       clk = 1'b0;
   logic       clrn;
   logic       prn;
   logic [0:0] d1;
   logic [0:0] q1;
   logic [0:0] qn1;
   logic [7:0] d8;
   logic [7:0] q8;
   logic [7:0] qn8;
`ifdef D_FF_CLK_ENABLE_EN
   logic       ena;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic       d;
      logic       en;
      logic [7:0] d8;
   } vec_t;

   typedef struct {
      logic       q;
      logic [7:0] q8;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   d_ff #(.WIDTH(1)) u_dut1 (
      .prn  (prn),
      .clk  (clk),
      .d    (d1),
      .clrn (clrn),
      .q    (q1),
      .qn   (qn1)
`ifdef D_FF_CLK_ENABLE_EN
      ,
      .ena  (ena)
`endif
   );

   d_ff #(.WIDTH(8)) u_dut8 (
      .prn  (prn),
      .clk  (clk),
      .d    (d8),
      .clrn (clrn),
      .q    (q8),
      .qn   (qn8)
`ifdef D_FF_CLK_ENABLE_EN
      ,
      .ena  (ena)
`endif
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end else begin
         n_pass++;
         $display("ok   %s: %h at t=%0t", name, act, $time);
      end
   endtask

   // Compares both instances, true and complement outputs, against expected q values.
   task automatic check_all(input string name, input logic e1, input logic [7:0] e8);
      check({name, " q1"},  {7'b0, q1},  {7'b0, e1});
      check({name, " qn1"}, {7'b0, qn1}, {7'b0, ~e1});
      check({name, " q8"},  q8,  e8);
      check({name, " qn8"}, qn8, ~e8);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs[12];
      logic       m_q;
      logic [7:0] m_q8;
      logic       en_eff;
      exp_t       e;

      // t=0: clear asserted, no clock edge yet
      clrn = 1'b0; prn = 1'b1; d1 = 1'b0; d8 = 8'h00;
`ifdef D_FF_CLK_ENABLE_EN
      ena = 1'b1;
`endif
      #0.5 check_all("reset", 1'b0, 8'h00);
      #0.5 clrn = 1'b1;                                   // t=1
      #1   prn = 1'b0; d1 = 1'b1;                         // t=2
      #0.5 check_all("preset_async", 1'b1, 8'hFF);        // t=2.5
      #0.5 prn = 1'b1;                                    // t=3
      #0.5 check_all("preset_release_hold", 1'b1, 8'hFF); // t=3.5
      #0.5 d1 = 1'b0;                                     // t=4
      #1.5 check_all("edge5", 1'b0, 8'h00);               // t=5.5
      #0.5 d1 = 1'b1;                                     // t=6
      #2   d1 = 1'b0;                                     // t=8
      #1   d1 = 1'b1;                                     // t=9
      #0.5 check_all("hold9", 1'b0, 8'h00);               // t=9.5
      #1.5 d1 = 1'b0;                                     // t=11
      #3   d1 = 1'b1;                                     // t=14
      #0.5 check_all("hold14", 1'b0, 8'h00);              // t=14.5
      #1   check_all("edge15", 1'b1, 8'h00);              // t=15.5
      #0.5 d1 = 1'b0;                                     // t=16
      #2   d1 = 1'b1;                                     // t=18
      #1   d1 = 1'b0;                                     // t=19
      #2   d1 = 1'b1;                                     // t=21
      #3   d1 = 1'b0; d8 = 8'hA5;                         // t=24
      #0.5 check_all("hold24", 1'b1, 8'h00);              // t=24.5
      #1   check_all("edge25", 1'b0, 8'hA5);              // t=25.5
      // both controls asserted together: clear wins, edges ignored
      #4.5 clrn = 1'b0; prn = 1'b0; d1 = 1'b1;            // t=30
      #0.5 check_all("clr_and_pre", 1'b0, 8'h00);         // t=30.5
      #5   check_all("clr_blocks_edge", 1'b0, 8'h00);     // t=35.5
      #1.5 clrn = 1'b1; prn = 1'b1; d8 = 8'h3C;           // t=37
      #0.5 check_all("release_hold", 1'b0, 8'h00);        // t=37.5
      #8   check_all("edge45", 1'b1, 8'h3C);              // t=45.5
      // preset alone blocks clock edges
      #0.5 prn = 1'b0; d1 = 1'b0; d8 = 8'h00;             // t=46
      #9.5 check_all("pre_blocks_edge", 1'b1, 8'hFF);     // t=55.5
      #1.5 prn = 1'b1;                                    // t=57

      // synchronous vectors: the ena column only matters with the enable compiled in
      vecs[0]  = '{1'b0, 1'b1, 8'h5A};
      vecs[1]  = '{1'b1, 1'b0, 8'hC3};
      vecs[2]  = '{1'b1, 1'b1, 8'hA5};
      vecs[3]  = '{1'b0, 1'b1, 8'h01};
      vecs[4]  = '{1'b1, 1'b0, 8'h80};
      vecs[5]  = '{1'b0, 1'b0, 8'h7E};
      vecs[6]  = '{1'b1, 1'b1, 8'hFF};
      vecs[7]  = '{1'b1, 1'b1, 8'h00};
      vecs[8]  = '{1'b0, 1'b1, 8'h96};
      vecs[9]  = '{1'b1, 1'b0, 8'h69};
      vecs[10] = '{1'b0, 1'b1, 8'h3C};
      vecs[11] = '{1'b1, 1'b1, 8'hA5};
      m_q  = 1'b1;
      m_q8 = 8'hFF;

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         d1 = vecs[i].d;
         d8 = vecs[i].d8;
`ifdef D_FF_CLK_ENABLE_EN
         ena    = vecs[i].en;
         en_eff = vecs[i].en;
`else
         en_eff = 1'b1;
`endif
         if (en_eff) begin
            m_q  = vecs[i].d;
            m_q8 = vecs[i].d8;
         end
         e.q  = m_q;
         e.q8 = m_q8;
         sb_q.push_back(e);
         @(posedge clk);
         #1;
         if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1 at vec %0d", i);
         end else begin
            e = sb_q.pop_front();
            check_all($sformatf("vec%0d", i), e.q, e.q8);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_d_ff
